// File: rtl/hwpe_stream_tcdm_rr_arbiter.sv
// hwpe_stream_tcdm_rr_arbiter
// Round-robin arbiter that merges NB_IN TCDM-style requesters onto one shared
// port. It tracks up to MAX_OUTSTANDING granted-but-unanswered transactions in
// an ID FIFO and routes each response back to its requester in grant order.
//
// Ports
//   clk_i, rst_i, clear_i       clock, sync active-high reset, sync soft clear
//   in_req_i/add/data/be/wen    per-requester request fields (packed by index)
//   in_gnt_o                    per-requester grant (one-hot or zero)
//   in_r_data_o, in_r_valid_o   response data (broadcast) and per-requester valid
//   out_req_o/add/data/be/wen   shared-port request fields
//   out_gnt_i                   shared-port grant
//   out_r_data_i, out_r_valid_i shared-port response
//   empty_o, full_o             outstanding-count status
//   err_o                       sticky: response seen with nothing outstanding
module hwpe_stream_tcdm_rr_arbiter #(
  parameter int NB_IN           = 4,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                clear_i,
  input  logic [NB_IN-1:0]    in_req_i,
  input  logic [NB_IN*32-1:0] in_add_i,
  input  logic [NB_IN*32-1:0] in_data_i,
  input  logic [NB_IN*4-1:0]  in_be_i,
  input  logic [NB_IN-1:0]    in_wen_i,
  output logic [NB_IN-1:0]    in_gnt_o,
  output logic [31:0]         in_r_data_o,
  output logic [NB_IN-1:0]    in_r_valid_o,
  output logic                out_req_o,
  output logic [31:0]         out_add_o,
  output logic [31:0]         out_data_o,
  output logic [3:0]          out_be_o,
  output logic                out_wen_o,
  input  logic                out_gnt_i,
  input  logic [31:0]         out_r_data_i,
  input  logic                out_r_valid_i,
  output logic                empty_o,
  output logic                full_o,
  output logic                err_o
);

  localparam int ID_W  = (NB_IN > 1) ? $clog2(NB_IN) : 1;
  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [ID_W-1:0]  rr_q;
  logic             lock_q;
  logic [ID_W-1:0]  lock_id_q;
  logic [CNT_W-1:0] count_q;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic             err_q;
  logic [ID_W-1:0]  id_fifo [MAX_OUTSTANDING];

  logic             kill;
  logic             any_req;
  logic             hs;
  logic             resp_hit;
  logic             orphan;
  logic [ID_W-1:0]  win;
  logic [ID_W-1:0]  head;
  logic [ID_W-1:0]  rr_next;
  logic             found;
  int               idx;

  assign kill     = rst_i | clear_i;
  assign any_req  = |in_req_i;
  assign empty_o  = (count_q == '0);
  assign full_o   = (count_q == CNT_W'(MAX_OUTSTANDING));
  assign err_o    = err_q;

  // full_o is registered, so a response in a full cycle cannot free a slot
  // for a request in that same cycle.
  assign out_req_o = any_req & ~full_o & ~kill;
  assign hs        = out_req_o & out_gnt_i;

  // Responses with nothing outstanding (including those for transactions
  // granted before a reset/clear) are orphans: never routed, only flagged.
  assign resp_hit    = out_r_valid_i & ~empty_o & ~kill;
  assign orphan      = out_r_valid_i & empty_o & ~kill;
  assign head        = id_fifo[rd_ptr_q];
  assign in_r_data_o = out_r_data_i;
  assign rr_next     = (win == ID_W'(NB_IN - 1)) ? '0 : win + 1'b1;

  // Winner: a locked requester that still asserts req keeps the port;
  // otherwise scan upward from rr_q with wrap.
  always_comb begin
    win   = rr_q;
    found = 1'b0;
    idx   = 0;
    if (lock_q && in_req_i[lock_id_q]) begin
      win = lock_id_q;
    end else begin
      for (int k = 0; k < NB_IN; k++) begin
        idx = int'(rr_q) + k;
        if (idx >= NB_IN) idx = idx - NB_IN;
        if (!found && in_req_i[idx]) begin
          win   = ID_W'(idx);
          found = 1'b1;
        end
      end
    end
  end

  always_comb begin
    out_add_o    = '0;
    out_data_o   = '0;
    out_be_o     = '0;
    out_wen_o    = 1'b0;
    in_gnt_o     = '0;
    in_r_valid_o = '0;
    for (int i = 0; i < NB_IN; i++) begin
      if (any_req && win == ID_W'(i)) begin
        out_add_o  = in_add_i[i*32 +: 32];
        out_data_o = in_data_i[i*32 +: 32];
        out_be_o   = in_be_i[i*4 +: 4];
        out_wen_o  = in_wen_i[i];
      end
      in_gnt_o[i]     = hs & (win == ID_W'(i));
      in_r_valid_o[i] = resp_hit & (head == ID_W'(i));
    end
  end

  // Control state: arbitration pointer, lock, FIFO pointers, count, error
  always_ff @(posedge clk_i) begin
    if (kill) begin
      rr_q      <= '0;
      lock_q    <= 1'b0;
      lock_id_q <= '0;
      count_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      if (hs) begin
        rr_q     <= rr_next;
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (resp_hit) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({hs, resp_hit})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (hs) begin
        lock_q <= 1'b0;
      end else if (out_req_o) begin
        lock_q    <= 1'b1;
        lock_id_q <= win;
      end else if (lock_q && !in_req_i[lock_id_q]) begin
        lock_q <= 1'b0;
      end
      if (orphan) err_q <= 1'b1;
    end
  end

  // ID storage: contents are only meaningful between the pointers
  always_ff @(posedge clk_i) begin
    if (hs) id_fifo[wr_ptr_q] <= win;
  end

endmodule
